// File: rtl/bool_sweep_pkg.sv
// Shared types and constants for the exhaustive boolean truth-table sweeper.
package bool_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        WAIT   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_e;

    // Lab function d = (~a|~b)&~c, bit i = output for vector i (a is the vector MSB).
    localparam logic [7:0] LAB_EXPECTED = 8'h15;

    function automatic int tbl_width(input int n_in);
        return 32'sd1 << n_in;
    endfunction

endpackage

// File: rtl/bool_sweep_checker_settle_timer.sv
// Loadable down-counter: expire_o is high while the count sits at 1.
module settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/bool_sweep_checker.sv
// Exhaustive truth-table driver/checker for an N_IN-input, 1-output boolean block.
// Optional macro BOOL_SWEEP_STOP_ON_FAIL_EN: stop at first mismatch and report fail_idx_o.
module bool_sweep_checker
    import bool_sweep_pkg::*;
#(
    parameter int                           N_IN       = 3,
    parameter logic [tbl_width(N_IN)-1:0]   EXPECTED   = LAB_EXPECTED,
    parameter int                           SETTLE_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    output logic [N_IN-1:0]            dut_in_o,
    input  logic                       dut_out_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic [tbl_width(N_IN)-1:0] captured_o,
    output logic [N_IN:0]              err_count_o
`ifdef BOOL_SWEEP_STOP_ON_FAIL_EN
    ,
    output logic [N_IN-1:0]            fail_idx_o
`endif
);

    localparam int              TW       = tbl_width(N_IN);
    localparam int              CW       = $clog2(SETTLE_CYC + 2);
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TW - 1);

    state_e            state_q;
    logic [N_IN-1:0]   idx_q;
    logic [N_IN-1:0]   dut_in_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [TW-1:0]     captured_q;
    logic [N_IN:0]     err_q;
    logic              mismatch_d;
    logic              finish_d;
    logic [N_IN:0]     err_d;
    logic              load_d;
    logic              expire_s;
`ifdef BOOL_SWEEP_STOP_ON_FAIL_EN
    logic [N_IN-1:0]   fail_idx_q;
`endif

    // Per-vector compare result and end-of-sweep decision.
    always_comb begin
        mismatch_d = (dut_out_i != EXPECTED[idx_q]);
        err_d      = err_q + {{N_IN{1'b0}}, mismatch_d};
        load_d     = (state_q == DRIVE);
`ifdef BOOL_SWEEP_STOP_ON_FAIL_EN
        finish_d   = (idx_q == IDX_LAST) || mismatch_d;
`else
        finish_d   = (idx_q == IDX_LAST);
`endif
    end

    settle_timer #(.W(CW)) u_settle (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_d),
        .load_val_i (CW'(SETTLE_CYC)),
        .expire_o   (expire_s)
    );

    // Sweep FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= {N_IN{1'b0}};
            dut_in_q   <= {N_IN{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= {TW{1'b0}};
            err_q      <= {(N_IN+1){1'b0}};
`ifdef BOOL_SWEEP_STOP_ON_FAIL_EN
            fail_idx_q <= {N_IN{1'b0}};
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        captured_q <= {TW{1'b0}};
                        err_q      <= {(N_IN+1){1'b0}};
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        idx_q      <= {N_IN{1'b0}};
                        busy_q     <= 1'b1;
`ifdef BOOL_SWEEP_STOP_ON_FAIL_EN
                        fail_idx_q <= {N_IN{1'b0}};
`endif
                        state_q    <= DRIVE;
                    end
                end
                DRIVE: begin
                    dut_in_q <= idx_q;
                    state_q  <= (SETTLE_CYC == 0) ? SAMPLE : WAIT;
                end
                WAIT: begin
                    if (expire_s) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    captured_q[idx_q] <= dut_out_i;
                    err_q             <= err_d;
                    if (finish_d) begin
`ifdef BOOL_SWEEP_STOP_ON_FAIL_EN
                        if (mismatch_d) begin
                            fail_idx_q <= idx_q;
                        end
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == {(N_IN+1){1'b0}});
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + N_IN'(1);
                        state_q <= DRIVE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dut_in_o    = dut_in_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign captured_o  = captured_q;
    assign err_count_o = err_q;
`ifdef BOOL_SWEEP_STOP_ON_FAIL_EN
    assign fail_idx_o  = fail_idx_q;
`endif

endmodule

// File: tb/tb_bool_sweep_checker.sv
// Table-driven bench for bool_sweep_checker: default settle and zero-settle instances.
module tb_bool_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    int         mode;
    int         cur_inst;
    int         n_checks = 0;
    int         n_fail   = 0;

    logic [2:0] dut_in0, dut_in1;
    logic       dut_out0, dut_out1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [7:0] cap0, cap1;
    logic [3:0] err0, err1;
    logic [2:0] fidx0, fidx1;

    logic       sel_busy, sel_done, sel_pass;
    logic [7:0] sel_cap;
    logic [3:0] sel_err;
    logic [2:0] sel_fidx;

    always #5 clk = ~clk;

    function automatic logic model(input int m, input logic [2:0] v);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return (~v[2] | ~v[1]) & ~v[0];
        endcase
    endfunction

    always_comb begin
        dut_out0 = model(mode, dut_in0);
        dut_out1 = model(mode, dut_in1);
    end

    always_comb begin
        if (cur_inst == 0) begin
            sel_busy = busy0; sel_done = done0; sel_pass = pass0;
            sel_cap  = cap0;  sel_err  = err0;  sel_fidx = fidx0;
        end else begin
            sel_busy = busy1; sel_done = done1; sel_pass = pass1;
            sel_cap  = cap1;  sel_err  = err1;  sel_fidx = fidx1;
        end
    end

`ifndef BOOL_SWEEP_STOP_ON_FAIL_EN
    assign fidx0 = 3'd0;
    assign fidx1 = 3'd0;
`endif

    bool_sweep_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start0),
        .dut_in_o(dut_in0), .dut_out_i(dut_out0),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .captured_o(cap0), .err_count_o(err0)
`ifdef BOOL_SWEEP_STOP_ON_FAIL_EN
        , .fail_idx_o(fidx0)
`endif
    );

    bool_sweep_checker #(.SETTLE_CYC(0)) u_fast (
        .clk(clk), .rst_n(rst_n), .start_i(start1),
        .dut_in_o(dut_in1), .dut_out_i(dut_out1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .captured_o(cap1), .err_count_o(err1)
`ifdef BOOL_SWEEP_STOP_ON_FAIL_EN
        , .fail_idx_o(fidx1)
`endif
    );

    typedef struct {
        int         inst;
        int         mode;
        logic [7:0] cap;
        logic [3:0] err;
        logic       pass;
        int         lat;
        logic [2:0] fidx;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int inst, input logic v);
        if (inst == 0) start0 = v;
        else           start1 = v;
    endtask

    // Start a sweep, check the accept-cycle state, and count cycles until done.
    task automatic run_sweep(input int inst, input bit hold, output int lat);
        cur_inst = inst;
        @(posedge clk); #1;
        set_start(inst, 1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(inst, 1'b0);
        chk("busy_rise", {31'd0, sel_busy}, 32'd1);
        chk("done_clr",  {31'd0, sel_done}, 32'd0);
        chk("cap_clr",   {24'd0, sel_cap},  32'd0);
        chk("err_clr",   {28'd0, sel_err},  32'd0);
        lat = 0;
        while (!sel_done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        set_start(inst, 1'b0);
        if (!sel_done) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat;
        int k;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; mode = 0; cur_inst = 0;

        tbl[0] = '{0, 0, 8'h15, 4'd0, 1'b1, 32, 3'd0};
        tbl[3] = '{1, 0, 8'h15, 4'd0, 1'b1, 16, 3'd0};
        tbl[4] = '{0, 0, 8'h15, 4'd0, 1'b1, 32, 3'd0};
`ifdef BOOL_SWEEP_STOP_ON_FAIL_EN
        tbl[1] = '{0, 1, 8'h00, 4'd1, 1'b0,  4, 3'd0};
        tbl[2] = '{0, 2, 8'h03, 4'd1, 1'b0,  8, 3'd1};
        tbl[5] = '{1, 2, 8'h03, 4'd1, 1'b0,  4, 3'd1};
`else
        tbl[1] = '{0, 1, 8'h00, 4'd3, 1'b0, 32, 3'd0};
        tbl[2] = '{0, 2, 8'hFF, 4'd5, 1'b0, 32, 3'd0};
        tbl[5] = '{1, 2, 8'hFF, 4'd5, 1'b0, 16, 3'd0};
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   {31'd0, busy0},   32'd0);
        chk("rst_done",   {31'd0, done0},   32'd0);
        chk("rst_pass",   {31'd0, pass0},   32'd0);
        chk("rst_cap",    {24'd0, cap0},    32'd0);
        chk("rst_err",    {28'd0, err0},    32'd0);
        chk("rst_dut_in", {29'd0, dut_in0}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            mode = tbl[i].mode;
            run_sweep(tbl[i].inst, 1'b0, lat);
            chk($sformatf("lat[%0d]", i),  lat,                    tbl[i].lat);
            chk($sformatf("cap[%0d]", i),  {24'd0, sel_cap},       {24'd0, tbl[i].cap});
            chk($sformatf("err[%0d]", i),  {28'd0, sel_err},       {28'd0, tbl[i].err});
            chk($sformatf("pass[%0d]", i), {31'd0, sel_pass},      {31'd0, tbl[i].pass});
            chk($sformatf("busy[%0d]", i), {31'd0, sel_busy},      32'd0);
`ifdef BOOL_SWEEP_STOP_ON_FAIL_EN
            chk($sformatf("fidx[%0d]", i), {29'd0, sel_fidx},      {29'd0, tbl[i].fidx});
`endif
        end

        // start held high for the whole sweep: exactly one sweep, then idle in DONE
        mode = 0;
        run_sweep(0, 1'b1, lat);
        chk("hold_lat", lat, 32'd32);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done", {31'd0, done0}, 32'd1);
        chk("hold_busy", {31'd0, busy0}, 32'd0);
        chk("hold_cap",  {24'd0, cap0},  32'h15);

        // asynchronous reset while vector 3 is on the DUT
        cur_inst = 0;
        @(posedge clk); #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        k = 0;
        while (dut_in0 != 3'd3 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("mid_idx3", {29'd0, dut_in0}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy",   {31'd0, busy0},   32'd0);
        chk("mid_done",   {31'd0, done0},   32'd0);
        chk("mid_cap",    {24'd0, cap0},    32'd0);
        chk("mid_err",    {28'd0, err0},    32'd0);
        chk("mid_dut_in", {29'd0, dut_in0}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_sweep(0, 1'b0, lat);
        chk("post_lat",  lat,               32'd32);
        chk("post_cap",  {24'd0, cap0},     32'h15);
        chk("post_pass", {31'd0, pass0},    32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bool_sweep_checker.md
Name: bool_sweep_checker

Overview:
- Exhaustive truth-table driver and checker for a small combinational boolean block with N_IN inputs and 1 output, such as the 3-input lab functions.
- Drives every input combination onto the DUT, waits for settling, samples the DUT output, and compares it with an expected truth table.
- Sits beside the boolean block on the board or in the bench: it drives the block's inputs and reads its output.
- Reports the captured table, the mismatch count and a pass flag.

Parameters:
- N_IN, 3, number of DUT inputs; sweep length is 2**N_IN vectors.
- EXPECTED, 8'h15, expected truth table, width 2**N_IN. Bit i is the expected output for input vector i, with the MSB of the vector on input a. The default encodes d = (~a|~b)&~c.
- SETTLE_CYC, 2, idle cycles between driving a vector and sampling; 0 is legal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; single-cycle or level.
- dut_in  out  N_IN  vector driven to the DUT inputs.
- dut_out  in  1  DUT output.
- busy  out  1  high while a sweep runs.
- done  out  1  high from sweep completion until the next accepted start.
- pass  out  1  valid only when done=1; 1 iff err_count==0.
- captured  out  2**N_IN  sampled DUT table; bit i = dut_out observed for vector i.
- err_count  out  N_IN+1  number of mismatching vectors.

Behaviour:
- Reset: one clock; asynchronous active-low reset (rst_n).
  - Values: dut_in=0, busy=0, done=0, pass=0, captured=0, err_count=0, state IDLE, idx=0, wait counter=0.
  - Reset asserted mid-sweep aborts immediately to these values. No partial result is kept.
- FSM states: IDLE, DRIVE, WAIT, SAMPLE, DONE.
- IDLE or DONE, start=1:
  - Clear captured, err_count and done; set idx=0 and busy=1.
  - Go to DRIVE.
- While busy: start is ignored. It is not queued.
- DRIVE (1 cycle):
  - dut_in<=idx; load the wait counter with SETTLE_CYC.
  - Next state is WAIT, or SAMPLE if SETTLE_CYC==0.
- WAIT (SETTLE_CYC cycles):
  - Decrement the counter; go to SAMPLE when it reaches 1.
  - dut_in stays stable.
- SAMPLE (1 cycle):
  - captured[idx]<=dut_out.
  - If dut_out!=EXPECTED[idx], err_count<=err_count+1. The counter cannot overflow: the maximum count is 2**N_IN.
  - If idx==2**N_IN-1, go to DONE. Otherwise idx<=idx+1 and go to DRIVE. idx wraps only through restart, never mid-sweep.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - dut_in holds the last vector.
  - Remain in DONE until start.
- Latency:
  - Each vector costs SETTLE_CYC+2 cycles.
  - done rises 2**N_IN*(SETTLE_CYC+2) cycles after the start-accept edge; 32 cycles with the defaults.
- dut_in changes only in DRIVE, so it is glitch-free at register level.
- dut_out is sampled only in SAMPLE.

Optional Feature:
- Macro: BOOL_SWEEP_STOP_ON_FAIL_EN.
- Defined:
  - The first mismatch in SAMPLE goes directly to DONE, with err_count=1.
  - An extra output fail_idx [N_IN-1:0] holds the failing vector. It is 0 at reset and on start.
  - captured bits above fail_idx remain 0.
- Undefined:
  - A full sweep always runs and counts all mismatches.
  - The fail_idx port does not exist.

Decomposition:
- Package bool_sweep_pkg holds:
  - the state enum (IDLE, DRIVE, WAIT, SAMPLE, DONE);
  - the function for table width (2**N_IN);
  - the default EXPECTED constant for the lab function.
- One natural sub-module: settle_timer, a loadable down-counter. It has inputs load and load_val and an output expire, and it is reused by other lab benches.

Test Plan:
- Correct DUT (d=(~a|~b)&~c), defaults, 1-cycle start pulse:
  - busy rises next cycle; done rises 32 cycles after acceptance.
  - captured=8'h15, err_count=0, pass=1.
- DUT output stuck at 0 -> captured=8'h00, err_count=3, pass=0.
- DUT output stuck at 1 -> captured=8'hFF, err_count=5, pass=0.
- Timing and start handling:
  - SETTLE_CYC=0 with correct DUT -> done after 16 cycles, captured=8'h15.
  - start held high for the whole sweep -> exactly one sweep.
  - After done, a second start clears the outputs and repeats identically.
- Reset mid-sweep:
  - rst_n low while idx=3 -> all outputs return to 0 asynchronously, before the next clock edge.
  - After release, a new start completes with captured=8'h15.
- With BOOL_SWEEP_STOP_ON_FAIL_EN and DUT stuck at 1:
  - done after 8 cycles, fail_idx=1, err_count=1, captured=8'h03, pass=0.
